// File: rtl/despachador_colas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : despachador_colas_pkg
//  Description : Shared defaults, widths and helpers for the queue dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
package despachador_colas_pkg;

    localparam int unsigned QUEUE_QUANTITY_DEF = 4;
    localparam int unsigned DATA_BITS_DEF      = 8;
    localparam int unsigned BUF_DEPTH          = 2;
    localparam int unsigned COUNT_BITS         = 2;

    typedef logic [COUNT_BITS-1:0] count_t;

    // A single queue still needs a 1-bit selector.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_BITS_DEF = idx_bits(QUEUE_QUANTITY_DEF);

endpackage
`default_nettype wire

// File: rtl/despachador_colas_if.sv
`default_nettype none
// ============================================================================
//  Module      : despachador_colas_if
//  Description : Grant, FIFO-bank and output-handshake bundle of the dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface despachador_colas_if
    import despachador_colas_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
    parameter int unsigned DATA_BITS      = DATA_BITS_DEF
) ();

    localparam int unsigned IW = idx_bits(QUEUE_QUANTITY);

    logic                                enb;
    logic [IW-1:0]                       selector;
    logic                                selector_enb;
    logic [QUEUE_QUANTITY-1:0]           buf_empty;
    logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data;
    logic [QUEUE_QUANTITY-1:0]           pop;
    logic [DATA_BITS-1:0]                data_out;
    logic [IW-1:0]                       queue_out;
    logic                                valid_out;
    logic                                ready_in;
    logic                                error_pop;

    modport master (
        output enb, selector, selector_enb, buf_empty, fifo_data, ready_in,
        input  pop, data_out, queue_out, valid_out, error_pop
    );

    modport slave (
        input  enb, selector, selector_enb, buf_empty, fifo_data, ready_in,
        output pop, data_out, queue_out, valid_out, error_pop
    );

endinterface
`default_nettype wire

// File: rtl/despachador_colas_buffer_salida.sv
`default_nettype none
// ============================================================================
//  Module      : buffer_salida
//  Description : 2-entry synchronous FIFO of {queue tag, data} words.
//  Revision    : 1.0 - initial release
// ============================================================================
module buffer_salida
    import despachador_colas_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_BITS_DEF + IDX_BITS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             write_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             read_i,
    output logic [WIDTH-1:0] rdata_o,
    output count_t           count_o
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    count_t           count_q;
    count_t           count_d;

    always_comb begin
        count_d = count_q;
        case ({write_i, read_i})
            2'b10:   count_d = count_q + count_t'(1);
            2'b01:   count_d = count_q - count_t'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (write_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (read_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/despachador_colas.sv
`default_nettype none
// ============================================================================
//  Module      : despachador_colas
//  Description : Pops the granted FIFO under output-buffer credit and delivers
//                tagged words through a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module despachador_colas
    import despachador_colas_pkg::*;
#(
    parameter int unsigned QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
    parameter int unsigned DATA_BITS      = DATA_BITS_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    despachador_colas_if.slave   bus
);

    localparam int unsigned IW = idx_bits(QUEUE_QUANTITY);
    localparam int unsigned EW = DATA_BITS + IW;
    localparam logic [COUNT_BITS:0] CREDIT_LIMIT = (COUNT_BITS+1)'(BUF_DEPTH);

    logic                inflight_q;
    logic                inflight_d;
    logic [IW-1:0]       sel_q;
    logic [IW-1:0]       sel_d;

    logic                w_sel_empty;
    logic                w_grant;
    logic                w_valid;
    logic                w_accept;
    logic                w_pop_ok;
    logic [COUNT_BITS:0] w_used;
    logic [COUNT_BITS:0] w_limit;
    count_t              w_count;
    logic [EW-1:0]       w_wdata;
    logic [EW-1:0]       w_rdata;

    // Selectors past the last queue read as empty so they raise error_pop.
    always_comb begin
        w_sel_empty = 1'b1;
        for (int i = 0; i < QUEUE_QUANTITY; i++) begin
            if (bus.selector == IW'(i)) begin
                w_sel_empty = bus.buf_empty[i];
            end
        end
    end

    assign w_valid  = (w_count != '0);
    assign w_accept = w_valid && bus.ready_in;
    assign w_grant  = rst_ni && bus.enb && bus.selector_enb;

    // Credit: buffered words plus the one in flight, minus a same-cycle accept.
    assign w_used   = {1'b0, w_count} + {{COUNT_BITS{1'b0}}, inflight_q};
    assign w_limit  = CREDIT_LIMIT + {{COUNT_BITS{1'b0}}, w_accept};
    assign w_pop_ok = w_grant && !w_sel_empty && (w_used < w_limit);

    assign bus.error_pop = w_grant && w_sel_empty;

    for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_pop
        assign bus.pop[i] = w_pop_ok && (bus.selector == IW'(i));
    end

    always_comb begin
        inflight_d = w_pop_ok;
        sel_d      = w_pop_ok ? bus.selector : sel_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            sel_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            sel_q      <= sel_d;
        end
    end

    assign w_wdata = {sel_q, bus.fifo_data[sel_q*DATA_BITS +: DATA_BITS]};

    buffer_salida #(
        .WIDTH (EW)
    ) u_buffer_salida (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .write_i (inflight_q),
        .wdata_i (w_wdata),
        .read_i  (w_accept),
        .rdata_o (w_rdata),
        .count_o (w_count)
    );

    assign bus.valid_out = w_valid;
    assign bus.data_out  = w_rdata[DATA_BITS-1:0];
    assign bus.queue_out = w_rdata[EW-1 -: IW];

endmodule
`default_nettype wire

// File: tb/tb_despachador_colas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_despachador_colas
//  Description : Directed vector table plus randomized run against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_despachador_colas;

    localparam int unsigned QQ = 4;
    localparam int unsigned DB = 8;
    localparam logic [31:0] FDATA = 32'h3CA5_2110;

    logic clk;
    logic rst_n;

    despachador_colas_if #(.QUEUE_QUANTITY(QQ), .DATA_BITS(DB)) bus_if ();

    despachador_colas #(
        .QUEUE_QUANTITY (QQ),
        .DATA_BITS      (DB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       enb;
        logic       sen;
        logic [1:0] sel;
        logic [3:0] emp;
        logic [31:0] fdata;
        logic       rdy;
        logic [3:0] e_pop;
        logic       e_err;
        logic       e_valid;
        logic [7:0] e_data;
        logic [1:0] e_queue;
    } vec_t;

    typedef struct {
        logic [1:0] q;
        logic [7:0] d;
    } word_t;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: output buffer as a queue plus one pending capture.
    word_t      mq[$];
    bit         m_infl;
    logic [1:0] m_sel;

    vec_t tbl[$];

    function automatic vec_t mk(logic enb, logic sen, logic [1:0] sel, logic [3:0] emp,
                                logic rdy, logic [3:0] p, logic err, logic vld,
                                logic [7:0] d, logic [1:0] q);
        vec_t v;
        v.enb = enb; v.sen = sen; v.sel = sel; v.emp = emp; v.fdata = FDATA; v.rdy = rdy;
        v.e_pop = p; v.e_err = err; v.e_valid = vld; v.e_data = d; v.e_queue = q;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl = 1'b0;
        m_sel  = 2'd0;
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl);
        bit         acc;
        bit         sel_empty;
        bit         m_err;
        bit         m_pop_ok;
        logic [3:0] exp_pop;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [1:0] exp_queue;
        word_t      w;
        @(negedge clk);
        bus_if.enb          = v.enb;
        bus_if.selector_enb = v.sen;
        bus_if.selector     = v.sel;
        bus_if.buf_empty    = v.emp;
        bus_if.fifo_data    = v.fdata;
        bus_if.ready_in     = v.rdy;
        #1;
        acc       = (mq.size() > 0) && v.rdy;
        sel_empty = v.emp[v.sel];
        m_err     = v.enb && v.sen && sel_empty;
        m_pop_ok  = v.enb && v.sen && !sel_empty &&
                    (int'(mq.size()) + int'(m_infl) - int'(acc) < 2);
        exp_pop   = m_pop_ok ? (4'b0001 << v.sel) : 4'b0000;
        exp_valid = (mq.size() > 0);
        exp_data  = exp_valid ? mq[0].d : 8'h00;
        exp_queue = exp_valid ? mq[0].q : 2'd0;
        if (use_tbl) begin
            exp_pop = v.e_pop; m_err = v.e_err; exp_valid = v.e_valid;
            exp_data = v.e_data; exp_queue = v.e_queue;
        end
        chk("pop", 32'(bus_if.pop), 32'(exp_pop));
        chk("error_pop", 32'(bus_if.error_pop), 32'(m_err));
        chk("valid_out", 32'(bus_if.valid_out), 32'(exp_valid));
        if (exp_valid) begin
            chk("data_out", 32'(bus_if.data_out), 32'(exp_data));
            chk("queue_out", 32'(bus_if.queue_out), 32'(exp_queue));
        end
        if (acc) void'(mq.pop_front());
        if (m_infl) begin
            w.q = m_sel;
            w.d = v.fdata[m_sel*8 +: 8];
            mq.push_back(w);
        end
        if (mq.size() > 2) begin
            n_checks++;
            n_errors++;
            $display("FAIL model_overflow at %0t: occupancy %0d limit 2", $time, mq.size());
        end
        m_infl = m_pop_ok;
        m_sel  = v.sel;
        @(posedge clk);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus_if.enb = 1'b0; bus_if.selector_enb = 1'b0; bus_if.selector = '0;
        bus_if.buf_empty = '0; bus_if.fifo_data = FDATA; bus_if.ready_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pop", 32'(bus_if.pop), 32'h0);
        chk("reset_error_pop", 32'(bus_if.error_pop), 32'h0);
        chk("reset_valid", 32'(bus_if.valid_out), 32'h0);
        chk("reset_data", 32'(bus_if.data_out), 32'h0);
        chk("reset_queue", 32'(bus_if.queue_out), 32'h0);
        rst_n = 1'b1;

        // enb sen sel emp rdy | pop err vld data queue
        tbl.push_back(mk(1,1,2,4'h0,1, 4'b0100,0,0,8'h00,0));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'hA5,2));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,0,4'h0,1, 4'b0001,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h0,1, 4'b0010,0,0,8'h00,0));
        tbl.push_back(mk(1,1,2,4'h0,1, 4'b0100,0,1,8'h10,0));
        tbl.push_back(mk(1,1,3,4'h0,1, 4'b1000,0,1,8'h21,1));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'hA5,2));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'h3C,3));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h0,0, 4'b0010,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h0,0, 4'b0010,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h0,0, 4'b0000,0,1,8'h21,1));
        tbl.push_back(mk(1,1,1,4'h0,0, 4'b0000,0,1,8'h21,1));
        tbl.push_back(mk(1,1,1,4'h0,0, 4'b0000,0,1,8'h21,1));
        tbl.push_back(mk(1,1,1,4'h0,1, 4'b0010,0,1,8'h21,1));
        tbl.push_back(mk(1,1,1,4'h0,1, 4'b0010,0,1,8'h21,1));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'h21,1));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'h21,1));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h2,1, 4'b0000,1,0,8'h00,0));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,0,4'h0,0, 4'b0001,0,0,8'h00,0));
        tbl.push_back(mk(1,0,0,4'h0,0, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,1,4'h2,0, 4'b0000,1,1,8'h10,0));
        tbl.push_back(mk(1,0,0,4'h0,0, 4'b0000,0,1,8'h10,0));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,1,8'h10,0));
        tbl.push_back(mk(1,0,0,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(1,1,3,4'h0,1, 4'b1000,0,0,8'h00,0));
        tbl.push_back(mk(0,1,3,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(0,1,3,4'h0,1, 4'b0000,0,1,8'h3C,3));
        tbl.push_back(mk(0,1,3,4'h0,1, 4'b0000,0,0,8'h00,0));
        tbl.push_back(mk(0,1,2,4'h4,1, 4'b0000,0,0,8'h00,0));
        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // Reset with one word buffered and one in flight.
        run_cycle(mk(1,1,0,4'h0,0, 4'h0,0,0,8'h00,0), 1'b0);
        run_cycle(mk(1,1,1,4'h0,0, 4'h0,0,0,8'h00,0), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", 32'(bus_if.valid_out), 32'h0);
        chk("midreset_pop", 32'(bus_if.pop), 32'h0);
        chk("midreset_error_pop", 32'(bus_if.error_pop), 32'h0);
        chk("midreset_data", 32'(bus_if.data_out), 32'h0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        run_cycle(mk(1,1,2,4'h0,1, 4'h0,0,0,8'h00,0), 1'b0);
        run_cycle(mk(1,0,0,4'h0,1, 4'h0,0,0,8'h00,0), 1'b0);
        @(negedge clk);
        bus_if.selector_enb = 1'b0;
        #1;
        chk("post_reset_valid", 32'(bus_if.valid_out), 32'h1);
        chk("post_reset_data", 32'(bus_if.data_out), 32'hA5);
        chk("post_reset_queue", 32'(bus_if.queue_out), 32'h2);
        @(posedge clk);
        m_infl = 1'b0;
        void'(mq.pop_front());
        run_cycle(mk(1,0,0,4'h0,1, 4'h0,0,0,8'h00,0), 1'b0);

        for (int i = 0; i < 600; i++) begin
            v = mk(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                   2'($urandom_range(0, 3)), 4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                   ($urandom_range(0, 2) != 0), 4'h0, 0, 0, 8'h00, 0);
            v.fdata = $urandom;
            run_cycle(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/despachador_colas.md
# despachador_colas

Downstream stage of the weighted round-robin arbiter. Takes the arbiter's `selector`/`selector_enb` grant, pops one word from the granted input FIFO, and captures the word one cycle later. It delivers the word, tagged with its queue index, through a 2-entry output buffer with a valid/ready handshake toward the output port logic. It owns the `pop` lines of the FIFO bank and the flow control that keeps words from being lost under backpressure.

## Interface
- `QUEUE_QUANTITY`, 4: number of input FIFOs.
- `DATA_BITS`, 8: word width of each FIFO.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `enb` in 1: block enable; low means no new pops are issued.
- `selector` in clog2(QUEUE_QUANTITY): queue granted by the arbiter.
- `selector_enb` in 1: grant valid.
- `buf_empty` in QUEUE_QUANTITY: per-FIFO empty flags.
- `fifo_data` in QUEUE_QUANTITY*DATA_BITS: flattened FIFO read ports; queue i occupies bits [i*DATA_BITS +: DATA_BITS].
- `pop` out QUEUE_QUANTITY: one-hot read strobe to the FIFOs.
- `data_out` out DATA_BITS: head word of the output buffer.
- `queue_out` out clog2(QUEUE_QUANTITY): source queue of `data_out`.
- `valid_out` out 1: the output buffer is non-empty.
- `ready_in` in 1: downstream accepts the head word this cycle.
- `error_pop` out 1: one-cycle pulse when a grant hits an empty queue.

## Operation
- FIFO read latency is fixed at 1. A word popped in cycle N is valid on its `fifo_data` slice during cycle N+1.
- Accepted transfer: `valid_out && ready_in` at a rising edge.
- Pop condition, evaluated combinationally in cycle N: `rst` high, `enb`, `selector_enb`, `!buf_empty[selector]`, and `count + inflight - accept < 2`.
  - `count` is output-buffer occupancy, 0..2.
  - `inflight` is 1 if a pop was issued in cycle N-1.
  - `accept` is 1 if a transfer is accepted this cycle.
- When the pop condition holds:
  - `pop[selector]` = 1 and all other `pop` bits are 0.
  - At the edge: `inflight` <= 1 and `sel_q` <= `selector`.
- Otherwise `pop` = 0 and `inflight` <= 0.
- Capture: when `inflight` = 1, the slice `fifo_data[sel_q]` and the tag `sel_q` are written into the output buffer at the end of the cycle.
- Output buffer: 2-entry FIFO of {queue tag, data}.
  - A write and an accept in the same cycle leave `count` unchanged.
  - The credit rule guarantees no write ever arrives while `count` = 2.
- `error_pop` = 1 in any cycle where `enb && selector_enb && buf_empty[selector]`. No pop is issued in that cycle; there is no other state effect.
- `enb` low only blocks new pops. A capture already in flight completes, and the output buffer keeps draining.
- `selector` outside 0..QUEUE_QUANTITY-1 (non-power-of-2 configurations): treated as an empty queue, so `error_pop` pulses.

## Timing
- Reset values: `pop` = 0, `valid_out` = 0, `data_out` = 0, `queue_out` = 0, `error_pop` = 0. Internal `count`, `inflight`, and `sel_q` are all 0.
- `pop` and `error_pop` are combinational from registered arbiter outputs and internal state.
- Latency: pop in cycle N gives `valid_out` in cycle N+2 when the buffer was empty.
- Sustained throughput is 1 word/cycle while `ready_in` stays high and grants hit non-empty queues.
- `ready_in` low with the buffer full: the output stalls and `pop` stays 0 until an accept frees a slot. The freed slot can be reused in the same cycle because the credit rule includes `accept`.
- Reset asserted mid-operation: all state clears immediately. A word in flight (popped but not yet captured) is discarded; this loss is accepted and documented.
- `data_out` and `queue_out` hold their values while `valid_out` = 1 and `ready_in` = 0.

## Structure
- Shared header holds the `QUEUE_QUANTITY`/`DATA_BITS` defaults, the index width clog2(QUEUE_QUANTITY), and the buffer depth constant (2).
- One sub-module, `buffer_salida`: a 2-entry synchronous FIFO with async active-low reset. Its entry width is DATA_BITS + clog2(QUEUE_QUANTITY), and it exposes `count`, `write`, and `read`.
- Top level contains the credit/pop logic, the `inflight`/`sel_q` pipeline register, and the read mux.

## Test plan
- Reset, then grant queue 2 with `fifo_data[2]` = 8'hA5 and `ready_in` = 1 → `pop` = 4'b0100 for one cycle; two cycles later `valid_out` = 1, `data_out` = A5, `queue_out` = 2.
- Back-to-back grants 0,1,2,3 with `ready_in` = 1 → one pop per cycle; the outputs appear in order 0,1,2,3 on consecutive cycles.
- `ready_in` = 0 with continuous grants → exactly 2 pops issued, then `pop` stays 0. Raising `ready_in` drains the 2 words, and pops resume in the same cycle as the first accept.
- Grant queue 1 while `buf_empty[1]` = 1 → `pop` = 0 and `error_pop` = 1 for that cycle; `valid_out` is unchanged.
- `enb` dropped the cycle after a pop → the in-flight word is still delivered and no further pops occur.
- `rst` asserted low while a word is in flight and one is buffered → `valid_out` = 0 immediately. After release, the next grant delivers correctly with no stale word.
